// File: rtl/rob_unit.sv
// Reorder buffer: in-order allocate/retire, out-of-order completion, one-entry-per-cycle walk-back on mispredict.
// Define ROB_STATS_EN to add the stat_retired / stat_squashed event counters.

module rob_unit #(
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5,
  parameter int PREG_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  input  logic [PREG_W-1:0] alloc_pd_new,
  input  logic [PREG_W-1:0] alloc_pd_old,
  input  logic [31:0]       alloc_pc,
  output logic [IDX_W-1:0]  alloc_tag,
  input  logic              alu_done,
  input  logic [IDX_W-1:0]  alu_tag,
  input  logic              mem_done,
  input  logic [IDX_W-1:0]  mem_tag,
  input  logic              br_done,
  input  logic [IDX_W-1:0]  br_tag,
  input  logic              br_mispredict,
  output logic              retire_valid,
  output logic [IDX_W-1:0]  retire_tag,
  output logic [PREG_W-1:0] retire_pd_new,
  output logic [PREG_W-1:0] retire_pd_old,
  output logic [31:0]       retire_pc,
  output logic              squash_valid,
  output logic [PREG_W-1:0] squash_pd_new,
  output logic [PREG_W-1:0] squash_pd_old,
  output logic              rollback_busy,
  output logic              rob_empty
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]       stat_retired,
  output logic [31:0]       stat_squashed
`endif
);

  // Allocation handshake: an entry is taken on a clk edge where alloc_valid and
  // alloc_ready are both high; alloc_ready never depends on alloc_valid.
  typedef enum logic [0:0] {IDLE = 1'b0, ROLLBACK = 1'b1} state_t;

  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W:0]   CNT_FULL = (IDX_W+1)'(DEPTH);

  state_t            state, state_next;
  logic [IDX_W-1:0]  head, tail, target, target_next;
  logic [IDX_W:0]    count, count_next;
  logic [DEPTH-1:0]  ent_valid, ent_complete;
  logic [PREG_W-1:0] ent_pd_new [DEPTH];
  logic [PREG_W-1:0] ent_pd_old [DEPTH];
  logic [31:0]       ent_pc     [DEPTH];

  logic             full, mispredict, br_tag_valid, nested_ok;
  logic             alloc_fire, retire_fire, squash_fire;
  logic [IDX_W-1:0] tail_prev, br_next, br_age, branch_age;

  assign full         = (count == CNT_FULL);
  assign mispredict   = br_done && br_mispredict;
  assign br_tag_valid = ent_valid[br_tag];
  assign tail_prev    = tail - IDX_ONE;
  assign br_next      = br_tag + IDX_ONE;

  // Ages are distances from head; target-1 is the branch currently being recovered.
  assign br_age     = br_tag - head;
  assign branch_age = target - IDX_ONE - head;
  assign nested_ok  = mispredict && br_tag_valid && (br_age < branch_age);

  assign alloc_ready = (state == IDLE) && !full && !mispredict;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail;
  assign retire_fire = (state == IDLE) && ent_valid[head] && ent_complete[head];
  assign squash_fire = (state == ROLLBACK);

  assign rollback_busy = squash_fire;
  assign rob_empty     = (count == '0);
  assign count_next    = count + (IDX_W+1)'(alloc_fire)
                               - (IDX_W+1)'(retire_fire)
                               - (IDX_W+1)'(squash_fire);

  always_comb begin
    state_next  = state;
    target_next = target;
    case (state)
      IDLE: begin
        if (mispredict && br_tag_valid) begin
          target_next = br_next;
          if (br_next != tail) state_next = ROLLBACK;
        end
      end
      ROLLBACK: begin
        // A nested target is always older than the entry popped this cycle.
        if (nested_ok) target_next = br_next;
        if (tail_prev == target_next) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    retire_valid  = retire_fire;
    retire_tag    = '0;
    retire_pd_new = '0;
    retire_pd_old = '0;
    retire_pc     = '0;
    squash_valid  = squash_fire;
    squash_pd_new = '0;
    squash_pd_old = '0;
    if (retire_fire) begin
      retire_tag    = head;
      retire_pd_new = ent_pd_new[head];
      retire_pd_old = ent_pd_old[head];
      retire_pc     = ent_pc[head];
    end
    if (squash_fire) begin
      squash_pd_new = ent_pd_new[tail_prev];
      squash_pd_old = ent_pd_old[tail_prev];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      head         <= '0;
      tail         <= '0;
      target       <= '0;
      count        <= '0;
      ent_valid    <= '0;
      ent_complete <= '0;
    end else begin
      state  <= state_next;
      target <= target_next;
      count  <= count_next;
      if (alu_done && ent_valid[alu_tag]) ent_complete[alu_tag] <= 1'b1;
      if (mem_done && ent_valid[mem_tag]) ent_complete[mem_tag] <= 1'b1;
      if (br_done && br_tag_valid)        ent_complete[br_tag]  <= 1'b1;
      if (alloc_fire) begin
        ent_valid[tail]    <= 1'b1;
        ent_complete[tail] <= 1'b0;
        tail               <= tail + IDX_ONE;
      end
      if (retire_fire) begin
        ent_valid[head] <= 1'b0;
        head            <= head + IDX_ONE;
      end
      if (squash_fire) begin
        ent_valid[tail_prev] <= 1'b0;
        tail                 <= tail_prev;
      end
    end
  end

  // Payload needs no reset: it is only read while the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      ent_pd_new[tail] <= alloc_pd_new;
      ent_pd_old[tail] <= alloc_pd_old;
      ent_pc[tail]     <= alloc_pc;
    end
  end

`ifdef ROB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_retired  <= '0;
      stat_squashed <= '0;
    end else begin
      if (retire_fire) stat_retired  <= stat_retired + 32'd1;
      if (squash_fire) stat_squashed <= stat_squashed + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_unit.sv
// Self-checking bench for rob_unit: directed scenarios plus random traffic against a queue-based
// program-order model. Stat counters are checked when ROB_STATS_EN is defined.

module tb_rob_unit;
  localparam int DEPTH  = 32;
  localparam int IDX_W  = 5;
  localparam int PREG_W = 7;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              alloc_valid = 1'b0;
  logic              alloc_ready;
  logic [PREG_W-1:0] alloc_pd_new = '0;
  logic [PREG_W-1:0] alloc_pd_old = '0;
  logic [31:0]       alloc_pc = '0;
  logic [IDX_W-1:0]  alloc_tag;
  logic              alu_done = 1'b0;
  logic [IDX_W-1:0]  alu_tag = '0;
  logic              mem_done = 1'b0;
  logic [IDX_W-1:0]  mem_tag = '0;
  logic              br_done = 1'b0;
  logic [IDX_W-1:0]  br_tag = '0;
  logic              br_mispredict = 1'b0;
  logic              retire_valid;
  logic [IDX_W-1:0]  retire_tag;
  logic [PREG_W-1:0] retire_pd_new, retire_pd_old;
  logic [31:0]       retire_pc;
  logic              squash_valid;
  logic [PREG_W-1:0] squash_pd_new, squash_pd_old;
  logic              rollback_busy, rob_empty;
`ifdef ROB_STATS_EN
  logic [31:0]       stat_retired, stat_squashed;
`endif

  rob_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old), .alloc_pc(alloc_pc),
    .alloc_tag(alloc_tag),
    .alu_done(alu_done), .alu_tag(alu_tag),
    .mem_done(mem_done), .mem_tag(mem_tag),
    .br_done(br_done), .br_tag(br_tag), .br_mispredict(br_mispredict),
    .retire_valid(retire_valid), .retire_tag(retire_tag),
    .retire_pd_new(retire_pd_new), .retire_pd_old(retire_pd_old), .retire_pc(retire_pc),
    .squash_valid(squash_valid), .squash_pd_new(squash_pd_new), .squash_pd_old(squash_pd_old),
    .rollback_busy(rollback_busy), .rob_empty(rob_empty)
`ifdef ROB_STATS_EN
    , .stat_retired(stat_retired), .stat_squashed(stat_squashed)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model: program-order list of live instructions ----------------
  typedef struct {
    logic [IDX_W-1:0]  tag;
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
    logic [31:0]       pc;
    bit                complete;
  } ent_t;

  ent_t        m_q[$];
  int          m_head = 0;
  bit          m_rb = 0;
  int          m_keep = 0;
  int unsigned m_ret = 0;
  int unsigned m_sq = 0;

  logic [IDX_W-1:0] exp_q[$];
  logic [PREG_W-1:0] pd_by_tag [DEPTH];

  logic              exp_alloc_ready, exp_retire_valid, exp_squash_valid, exp_busy, exp_empty;
  logic [IDX_W-1:0]  exp_alloc_tag, exp_retire_tag;
  logic [PREG_W-1:0] exp_retire_pd_new, exp_retire_pd_old, exp_squash_pd_new, exp_squash_pd_old;
  logic [31:0]       exp_retire_pc;

  function automatic int pos_of(logic [IDX_W-1:0] t);
    return (int'(t) - m_head + DEPTH) % DEPTH;
  endfunction

  task automatic predict();
    int sz;
    sz = m_q.size();
    exp_alloc_ready   = !m_rb && (sz < DEPTH) && !(br_done && br_mispredict);
    exp_alloc_tag     = IDX_W'((m_head + sz) % DEPTH);
    exp_retire_valid  = !m_rb && (sz > 0) && m_q[0].complete;
    exp_retire_tag    = '0;
    exp_retire_pd_new = '0;
    exp_retire_pd_old = '0;
    exp_retire_pc     = '0;
    if (exp_retire_valid) begin
      exp_retire_tag    = m_q[0].tag;
      exp_retire_pd_new = m_q[0].pd_new;
      exp_retire_pd_old = m_q[0].pd_old;
      exp_retire_pc     = m_q[0].pc;
    end
    exp_squash_valid  = m_rb;
    exp_squash_pd_new = '0;
    exp_squash_pd_old = '0;
    if (m_rb) begin
      exp_squash_pd_new = m_q[sz-1].pd_new;
      exp_squash_pd_old = m_q[sz-1].pd_old;
    end
    exp_busy  = m_rb;
    exp_empty = (sz == 0);
  endtask

  task automatic model_update();
    int p, sz;
    ent_t e;
    sz = m_q.size();
    if (alu_done) begin p = pos_of(alu_tag); if (p < sz) m_q[p].complete = 1; end
    if (mem_done) begin p = pos_of(mem_tag); if (p < sz) m_q[p].complete = 1; end
    if (br_done)  begin p = pos_of(br_tag);  if (p < sz) m_q[p].complete = 1; end
    if (br_done && br_mispredict) begin
      p = pos_of(br_tag);
      if (p < sz) begin
        if (!exp_squash_valid) begin
          if (p + 1 < sz) begin m_rb = 1; m_keep = p + 1; end
        end else if (p < m_keep - 1) begin
          m_keep = p + 1;
        end
      end
    end
    if (exp_squash_valid) begin
      void'(m_q.pop_back());
      m_sq++;
      if (m_q.size() == m_keep) m_rb = 0;
    end
    if (exp_retire_valid) begin
      void'(m_q.pop_front());
      m_head = (m_head + 1) % DEPTH;
      m_ret++;
      if (m_rb) m_keep--;
    end
    if (alloc_valid && exp_alloc_ready) begin
      e.tag = exp_alloc_tag; e.pd_new = alloc_pd_new; e.pd_old = alloc_pd_old;
      e.pc = alloc_pc; e.complete = 0;
      m_q.push_back(e);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    alloc_valid = 0; alu_done = 0; mem_done = 0; br_done = 0; br_mispredict = 0;
  endtask

  task automatic settle();
    #1;
    predict();
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic model_clear();
    m_q.delete(); m_head = 0; m_rb = 0; m_keep = 0; m_ret = 0; m_sq = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_clear();
  endtask

  task automatic drive_alloc(int tag);
    alloc_valid  = 1;
    alloc_pd_new = PREG_W'(40 + (tag % 64));
    alloc_pd_old = PREG_W'($urandom_range(0, 127));
    alloc_pc     = $urandom;
    pd_by_tag[tag % DEPTH] = alloc_pd_new;
  endtask

  task automatic alloc_n(int n);
    for (int i = 0; i < n; i++) begin
      drive_alloc((m_head + m_q.size()) % DEPTH);
      tick();
    end
    clear_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    settle();
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_alloc_ready got %0b exp 1", alloc_ready); end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL reset_rob_empty got %0b exp 1", rob_empty); end
    checks++; if (alloc_tag !== 5'd0) begin errors++; $display("FAIL reset_alloc_tag got %0d exp 0", alloc_tag); end
    checks++; if ({retire_valid, squash_valid, rollback_busy} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got %b exp 000", {retire_valid, squash_valid, rollback_busy}); end
    checks++; if ({retire_tag, retire_pd_new, retire_pd_old, retire_pc, squash_pd_new, squash_pd_old} !== '0) begin errors++;
      $display("FAIL reset_data got nonzero exp 0"); end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_alloc(i);
      settle();
      checks++; if (alloc_ready !== 1'b1 || alloc_tag !== IDX_W'(i)) begin errors++;
        $display("FAIL fill_alloc got rdy=%0b tag=%0d exp rdy=1 tag=%0d", alloc_ready, alloc_tag, i); end
      tick();
    end
    settle();
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_alloc_ready got %0b exp 0", alloc_ready); end
    tick();
    clear_inputs();
    for (int i = DEPTH - 1; i >= 0; i--) begin
      alu_done = 1; alu_tag = IDX_W'(i);
      settle();
      checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL fill_early_retire got %0b exp 0 at tag %0d", retire_valid, i); end
      tick();
    end
    clear_inputs();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(IDX_W'(i));
    for (int i = 0; i < DEPTH; i++) begin
      logic [IDX_W-1:0] t;
      t = exp_q.pop_front();
      settle();
      checks++; if (retire_valid !== 1'b1 || retire_tag !== t || retire_pd_new !== PREG_W'(40 + i)) begin errors++;
        $display("FAIL drain_retire got v=%0b tag=%0d pd=%0d exp v=1 tag=%0d pd=%0d", retire_valid, retire_tag, retire_pd_new, t, 40 + i); end
      tick();
    end
    settle();
    checks++; if (rob_empty !== 1'b1 || retire_valid !== 1'b0) begin errors++;
      $display("FAIL drain_empty got empty=%0b rv=%0b exp 1 0", rob_empty, retire_valid); end
  endtask

  task automatic test_ooo_complete();
    do_reset();
    alloc_n(3);
    alu_done = 1; alu_tag = 5'd2; tick(); clear_inputs();
    settle();
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL ooo_after2 got %0b exp 0", retire_valid); end
    mem_done = 1; mem_tag = 5'd1; tick(); clear_inputs();
    settle();
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL ooo_after1 got %0b exp 0", retire_valid); end
    alu_done = 1; alu_tag = 5'd0;
    settle();
    checks++; if (retire_valid !== 1'b0) begin errors++; $display("FAIL ooo_same_cycle got %0b exp 0", retire_valid); end
    tick(); clear_inputs();
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++; if (retire_valid !== 1'b1 || retire_tag !== IDX_W'(k) || retire_pd_old !== exp_retire_pd_old || retire_pc !== exp_retire_pc) begin errors++;
        $display("FAIL ooo_retire got v=%0b tag=%0d exp v=1 tag=%0d", retire_valid, retire_tag, k); end
      tick();
    end
    settle();
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL ooo_empty got %0b exp 1", rob_empty); end
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc_n(8);
    br_done = 1; br_mispredict = 1; br_tag = 5'd3;
    alloc_valid = 1;
    settle();
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL mp_alloc_block got %0b exp 0", alloc_ready); end
    tick(); clear_inputs();
    for (int k = 0; k < 4; k++) begin
      settle();
      checks++; if (squash_valid !== 1'b1 || rollback_busy !== 1'b1 || squash_pd_new !== pd_by_tag[7 - k]
                    || squash_pd_old !== exp_squash_pd_old) begin errors++;
        $display("FAIL mp_squash got v=%0b busy=%0b pd=%0d exp v=1 busy=1 pd=%0d", squash_valid, rollback_busy, squash_pd_new, pd_by_tag[7 - k]); end
      tick();
    end
    settle();
    checks++; if (squash_valid !== 1'b0 || rollback_busy !== 1'b0 || alloc_tag !== 5'd4) begin errors++;
      $display("FAIL mp_done got v=%0b busy=%0b tag=%0d exp 0 0 4", squash_valid, rollback_busy, alloc_tag); end
  endtask

  task automatic test_nested_mispredict();
    do_reset();
    alloc_n(10);
    br_done = 1; br_mispredict = 1; br_tag = 5'd5;
    tick(); clear_inputs();
    for (int k = 0; k < 7; k++) begin
      if (k == 0) begin br_done = 1; br_mispredict = 1; br_tag = 5'd2; end
      if (k == 6) begin br_done = 1; br_mispredict = 1; br_tag = 5'd8; end
      settle();
      checks++; if (squash_valid !== 1'b1 || squash_pd_new !== pd_by_tag[9 - k]) begin errors++;
        $display("FAIL nested_pop got v=%0b pd=%0d exp v=1 pd=%0d", squash_valid, squash_pd_new, pd_by_tag[9 - k]); end
      tick(); clear_inputs();
    end
    settle();
    checks++; if (squash_valid !== 1'b0 || rollback_busy !== 1'b0 || alloc_tag !== 5'd3) begin errors++;
      $display("FAIL nested_done got v=%0b busy=%0b tag=%0d exp 0 0 3", squash_valid, rollback_busy, alloc_tag); end
  endtask

  task automatic test_wrap_simultaneous();
    logic [IDX_W-1:0] wrap_tags [4];
    wrap_tags[0] = 5'd30; wrap_tags[1] = 5'd31; wrap_tags[2] = 5'd0; wrap_tags[3] = 5'd1;
    do_reset();
    alloc_n(30);
    for (int i = 0; i < 10; i++) begin
      alu_done = 1; alu_tag = IDX_W'(3 * i);
      mem_done = 1; mem_tag = IDX_W'(3 * i + 1);
      br_done  = 1; br_tag  = IDX_W'(3 * i + 2);
      tick();
    end
    clear_inputs();
    for (int k = 0; k < 40 && m_q.size() > 0; k++) tick();
    settle();
    checks++; if (rob_empty !== 1'b1 || alloc_tag !== 5'd30) begin errors++;
      $display("FAIL wrap_start got empty=%0b tag=%0d exp 1 30", rob_empty, alloc_tag); end
    for (int i = 0; i < 4; i++) begin
      drive_alloc(wrap_tags[i]);
      settle();
      checks++; if (alloc_tag !== wrap_tags[i]) begin errors++;
        $display("FAIL wrap_tag got %0d exp %0d", alloc_tag, wrap_tags[i]); end
      tick();
    end
    clear_inputs();
    alu_done = 1; alu_tag = 5'd30; tick(); clear_inputs();
    drive_alloc(2);
    settle();
    checks++; if (retire_valid !== 1'b1 || retire_tag !== 5'd30 || alloc_ready !== 1'b1 || alloc_tag !== 5'd2) begin errors++;
      $display("FAIL simul got rv=%0b rtag=%0d rdy=%0b atag=%0d exp 1 30 1 2", retire_valid, retire_tag, alloc_ready, alloc_tag); end
    tick(); clear_inputs();
    alu_done = 1; alu_tag = 5'd31; mem_done = 1; mem_tag = 5'd0; br_done = 1; br_tag = 5'd1;
    tick(); clear_inputs();
    exp_q.push_back(5'd31); exp_q.push_back(5'd0); exp_q.push_back(5'd1); exp_q.push_back(5'd2);
    for (int k = 0; k < 4; k++) begin
      logic [IDX_W-1:0] t;
      t = exp_q.pop_front();
      if (k == 0) begin alu_done = 1; alu_tag = 5'd2; end
      settle();
      checks++; if (retire_valid !== 1'b1 || retire_tag !== t) begin errors++;
        $display("FAIL wrap_retire got v=%0b tag=%0d exp v=1 tag=%0d", retire_valid, retire_tag, t); end
      tick(); clear_inputs();
    end
    settle();
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %0b exp 1", rob_empty); end
  endtask

  task automatic test_reset_mid_rollback();
    do_reset();
    alloc_n(8);
    br_done = 1; br_mispredict = 1; br_tag = 5'd2;
    tick(); clear_inputs();
    settle();
    checks++; if (squash_valid !== 1'b1) begin errors++; $display("FAIL rmid_started got %0b exp 1", squash_valid); end
    tick();
    do_reset();
    settle();
    checks++; if (squash_valid !== 1'b0 || rob_empty !== 1'b1 || alloc_tag !== 5'd0 || rollback_busy !== 1'b0) begin errors++;
      $display("FAIL rmid_reset got sv=%0b empty=%0b tag=%0d busy=%0b exp 0 1 0 0", squash_valid, rob_empty, alloc_tag, rollback_busy); end
  endtask

  function automatic logic [IDX_W-1:0] pick_tag();
    int sz;
    sz = m_q.size();
    if (sz > 0 && $urandom_range(0, 3) != 0) return IDX_W'((m_head + $urandom_range(0, sz - 1)) % DEPTH);
    return IDX_W'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic test_random();
    int bad;
    int p;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      alloc_valid  = ($urandom_range(0, 3) != 0);
      alloc_pd_new = PREG_W'($urandom_range(0, 127));
      alloc_pd_old = PREG_W'($urandom_range(0, 127));
      alloc_pc     = $urandom;
      alu_done = $urandom_range(0, 1); alu_tag = pick_tag();
      mem_done = $urandom_range(0, 1); mem_tag = pick_tag();
      br_done  = $urandom_range(0, 1); br_tag  = pick_tag();
      if (mem_done && alu_done && mem_tag == alu_tag) mem_done = 0;
      if (br_done && ((alu_done && br_tag == alu_tag) || (mem_done && br_tag == mem_tag))) br_done = 0;
      p = pos_of(br_tag);
      if (br_done && p < m_q.size() && m_q[p].complete) br_done = 0;
      br_mispredict = br_done && ($urandom_range(0, 7) == 0);
      settle();
      bad = 0;
      if (alloc_ready !== exp_alloc_ready) bad |= 1;
      if (exp_alloc_ready && alloc_tag !== exp_alloc_tag) bad |= 2;
      if (retire_valid !== exp_retire_valid || retire_tag !== exp_retire_tag || retire_pd_new !== exp_retire_pd_new
          || retire_pd_old !== exp_retire_pd_old || retire_pc !== exp_retire_pc) bad |= 4;
      if (squash_valid !== exp_squash_valid || squash_pd_new !== exp_squash_pd_new || squash_pd_old !== exp_squash_pd_old) bad |= 8;
      if (rollback_busy !== exp_busy || rob_empty !== exp_empty) bad |= 16;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL random cycle %0d got rdy=%0b rv=%0b rtag=%0d sv=%0b busy=%0b empty=%0b exp rdy=%0b rv=%0b rtag=%0d sv=%0b busy=%0b empty=%0b (mask %0d)",
                 c, alloc_ready, retire_valid, retire_tag, squash_valid, rollback_busy, rob_empty,
                 exp_alloc_ready, exp_retire_valid, exp_retire_tag, exp_squash_valid, exp_busy, exp_empty, bad);
      end
      tick();
    end
    clear_inputs();
`ifdef ROB_STATS_EN
    settle();
    checks++; if (stat_retired !== 32'(m_ret) || stat_squashed !== 32'(m_sq)) begin errors++;
      $display("FAIL stats got ret=%0d sq=%0d exp ret=%0d sq=%0d", stat_retired, stat_squashed, m_ret, m_sq); end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fill_drain();
    test_ooo_complete();
    test_mispredict();
    test_nested_mispredict();
    test_wrap_simultaneous();
    test_reset_mid_rollback();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
